frame_stream_ctrl: RTL
======================

// Module: frame_stream_ctrl
// PURPOSE
//  Sequences one BMP pixel-array stream into the frame_test datapath. Accepts raw bytes in
//  B,G,R order and assembles them into pixels. Strips the row padding that aligns each BMP
//  row to 4 bytes. Generates i_start_frame_flag/i_end_frame_flag for the datapath and
//  reports pixel coordinates and frame completion.
// PARAMETERS
//  W_BITS  12  width of frame-width input and x counter
//  H_BITS  12  width of frame-height input and y counter
// PORTS
//  i_clk               in   1       clock, single domain
//  i_rst               in   1       synchronous reset, active-high
//  i_frame_go          in   1       one-cycle pulse: latch i_width/i_height, start a frame
//  i_width             in   W_BITS  frame width in pixels
//  i_height            in   H_BITS  frame height in rows
//  i_byte              in   8       pixel-array byte from source
//  i_byte_valid        in   1       i_byte valid this cycle
//  o_byte_ready        out  1       byte accepted when i_byte_valid & o_byte_ready
//  o_color_b/g/r       out  8 each  assembled pixel to datapath
//  o_pix_valid         out  1       assembled pixel valid this cycle
//  o_start_frame_flag  out  1       high with first pixel of frame
//  o_end_frame_flag    out  1       high with last pixel of frame
//  o_x                 out  W_BITS  column of current o_color_* pixel
//  o_y                 out  H_BITS  row (stream order) of current pixel
//  o_busy              out  1       frame in progress (state != IDLE)
//  o_frame_done        out  1       one-cycle pulse, frame fully consumed
//  o_err               out  1       one-cycle pulse, i_frame_go with zero width/height
// BEHAVIOUR
//  - Reset: all outputs 0; state IDLE; all counters 0.
//  - States: IDLE -> PIX on i_frame_go (width,height != 0). PIX -> PAD at the end of a row
//    when pad != 0. PIX/PAD -> DONE after the last row's final byte. DONE -> IDLE after one cycle.
//  - pad = latched_width[1:0] bytes per row (equals (4 - 3*w mod 4) mod 4).
//  - o_byte_ready = 1 in PIX and PAD, 0 in IDLE and DONE.
//  - PIX: byte phase counter 0..2 advances only on accepted bytes (0=B, 1=G, 2=R).
//  - On the accepted R byte, the pixel is registered. o_pix_valid, o_color_*, o_x and o_y
//    update the following cycle (latency 1 cycle from R accept). o_pix_valid is 1 for exactly
//    that cycle.
//  - x increments per pixel and wraps to 0 after width-1. y increments on that wrap.
//  - o_start_frame_flag = o_pix_valid when x=0, y=0.
//  - o_end_frame_flag = o_pix_valid when x=width-1, y=height-1.
//  - width=1, height=1: start and end flags assert in the same cycle.
//  - PAD: consumes exactly pad accepted bytes. These bytes are discarded, and no output
//    changes except o_pix_valid=0. Then PIX continues with the next row, or goes to DONE
//    after the last row.
//  - o_frame_done pulses in the DONE cycle, which is at least 1 cycle after the end-flag pixel.
//  - o_color_* hold their last value when o_pix_valid=0. Flags are 0 whenever o_pix_valid=0.
//  - i_frame_go while o_busy: ignored. Latched width/height are unchanged.
//  - i_frame_go with i_width=0 or i_height=0 in IDLE: o_err pulses 1 cycle, state stays IDLE.
//  - Gaps in i_byte_valid: state, phase and counters hold. There is no timeout.
//  - Reset mid-frame: next cycle is IDLE, all outputs 0, and the partial pixel is discarded.
//  - i_rst has priority over i_frame_go in the same cycle.
// TESTING
//  - w=4, h=2, 24 bytes back-to-back -> 8 pixels. start with x=0,y=0; end with x=3,y=1.
//    frame_done 1 cycle after end pixel.
//  - w=3, h=2, 12 bytes/row (9 data + 3 pad 0xEE) -> 6 pixels, no 0xEE on o_color_*,
//    o_x sequence 0,1,2,0,1,2.
//  - w=2, h=2, random i_byte_valid gaps -> identical pixel values and x/y as the gap-free
//    run; o_pix_valid count = 4.
//  - i_frame_go with w=0, h=5 -> o_err 1 cycle, o_busy=0, o_byte_ready=0.
//  - w=4, h=2, reset after 5 accepted bytes -> all outputs 0 next cycle. New go gives first
//    pixel x=0,y=0 with start flag.
//  - w=1, h=1, bytes 11,22,33,PAD -> o_color_b/g/r=11/22/33 with start and end flags in the
//    same cycle. go during frame ignored. frame_done after pad byte.

Source files
------------

// File: rtl/frame_stream_ctrl_if.sv
// rtl/frame_stream_ctrl_if.sv - byte-in / pixel-out stream bundle for frame_stream_ctrl
// Purpose: groups the raw BMP byte handshake and the assembled pixel outputs.
// Signals:
//   i_byte, i_byte_valid, o_byte_ready          byte stream from the source
//   o_color_b/g/r, o_pix_valid                  assembled pixel to the datapath
//   o_start_frame_flag, o_end_frame_flag        frame boundary flags
//   o_x, o_y                                    pixel coordinates
// Modports: master = byte source / pixel sink, slave = frame_stream_ctrl.
interface frame_stream_ctrl_if #(
  parameter int W_BITS = 12,
  parameter int H_BITS = 12
);
  logic [7:0]        i_byte;
  logic              i_byte_valid;
  logic              o_byte_ready;
  logic [7:0]        o_color_b;
  logic [7:0]        o_color_g;
  logic [7:0]        o_color_r;
  logic              o_pix_valid;
  logic              o_start_frame_flag;
  logic              o_end_frame_flag;
  logic [W_BITS-1:0] o_x;
  logic [H_BITS-1:0] o_y;

  modport master (
    output i_byte, i_byte_valid,
    input  o_byte_ready, o_color_b, o_color_g, o_color_r, o_pix_valid,
    input  o_start_frame_flag, o_end_frame_flag, o_x, o_y
  );

  modport slave (
    input  i_byte, i_byte_valid,
    output o_byte_ready, o_color_b, o_color_g, o_color_r, o_pix_valid,
    output o_start_frame_flag, o_end_frame_flag, o_x, o_y
  );
endinterface

// File: rtl/frame_stream_ctrl.sv
// rtl/frame_stream_ctrl.sv - BMP pixel-array byte sequencer into the frame datapath
// Purpose: assembles B,G,R bytes into pixels, strips 4-byte row padding, tracks x/y,
//          and generates start/end-of-frame flags and frame completion.
// Ports:
//   i_clk, i_rst          clock, synchronous active-high reset
//   i_frame_go            one-cycle start pulse; latches i_width/i_height
//   i_width, i_height     frame size in pixels / rows
//   o_busy                frame in progress
//   o_frame_done          one-cycle pulse after the frame is fully consumed
//   o_err                 one-cycle pulse on a start with zero width or height
//   fs                    byte stream in / pixel stream out (slave modport)
module frame_stream_ctrl #(
  parameter int W_BITS = 12,
  parameter int H_BITS = 12
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_frame_go,
  input  logic [W_BITS-1:0]   i_width,
  input  logic [H_BITS-1:0]   i_height,
  output logic                o_busy,
  output logic                o_frame_done,
  output logic                o_err,
  frame_stream_ctrl_if.slave  fs
);

  typedef enum logic [1:0] {IDLE, PIX, PAD, DONE} state_t;

  state_t            state_q, state_d;
  logic [W_BITS-1:0] width_q, width_d;
  logic [H_BITS-1:0] height_q, height_d;
  logic [1:0]        phase_q, phase_d;
  logic [1:0]        pad_cnt_q, pad_cnt_d;
  logic [W_BITS-1:0] x_cnt_q, x_cnt_d;
  logic [H_BITS-1:0] y_cnt_q, y_cnt_d;
  logic [7:0]        b_hold_q, b_hold_d;
  logic [7:0]        g_hold_q, g_hold_d;
  logic [7:0]        color_b_q, color_b_d;
  logic [7:0]        color_g_q, color_g_d;
  logic [7:0]        color_r_q, color_r_d;
  logic              pix_valid_q, pix_valid_d;
  logic              start_q, start_d;
  logic              end_q, end_d;
  logic [W_BITS-1:0] x_q, x_d;
  logic [H_BITS-1:0] y_q, y_d;
  logic              done_q, done_d;
  logic              err_q, err_d;

  logic              byte_ready;
  logic              accept;
  logic [1:0]        pad;
  logic              last_col;
  logic              last_row;

  assign byte_ready = (state_q == PIX) || (state_q == PAD);
  assign accept     = fs.i_byte_valid && byte_ready;
  // 3*w mod 4 padding works out to exactly the low two bits of w.
  assign pad        = width_q[1:0];
  assign last_col   = (x_cnt_q == width_q - W_BITS'(1));
  assign last_row   = (y_cnt_q == height_q - H_BITS'(1));

  always_comb begin
    state_d     = state_q;
    width_d     = width_q;
    height_d    = height_q;
    phase_d     = phase_q;
    pad_cnt_d   = pad_cnt_q;
    x_cnt_d     = x_cnt_q;
    y_cnt_d     = y_cnt_q;
    b_hold_d    = b_hold_q;
    g_hold_d    = g_hold_q;
    color_b_d   = color_b_q;
    color_g_d   = color_g_q;
    color_r_d   = color_r_q;
    x_d         = x_q;
    y_d         = y_q;
    pix_valid_d = 1'b0;
    start_d     = 1'b0;
    end_d       = 1'b0;
    done_d      = 1'b0;
    err_d       = 1'b0;

    case (state_q)
      IDLE: begin
        if (i_frame_go) begin
          if ((i_width == '0) || (i_height == '0)) begin
            err_d = 1'b1;
          end else begin
            width_d   = i_width;
            height_d  = i_height;
            phase_d   = 2'd0;
            pad_cnt_d = 2'd0;
            x_cnt_d   = '0;
            y_cnt_d   = '0;
            state_d   = PIX;
          end
        end
      end

      PIX: begin
        if (accept) begin
          case (phase_q)
            2'd0: begin
              b_hold_d = fs.i_byte;
              phase_d  = 2'd1;
            end
            2'd1: begin
              g_hold_d = fs.i_byte;
              phase_d  = 2'd2;
            end
            default: begin
              phase_d     = 2'd0;
              color_b_d   = b_hold_q;
              color_g_d   = g_hold_q;
              color_r_d   = fs.i_byte;
              x_d         = x_cnt_q;
              y_d         = y_cnt_q;
              pix_valid_d = 1'b1;
              start_d     = (x_cnt_q == '0) && (y_cnt_q == '0);
              end_d       = last_col && last_row;
              if (last_col) begin
                x_cnt_d = '0;
                // y runs one past the last row so PAD can tell the frame is over.
                y_cnt_d = y_cnt_q + H_BITS'(1);
                if (pad != 2'd0) begin
                  state_d = PAD;
                end else if (last_row) begin
                  state_d = DONE;
                end
              end else begin
                x_cnt_d = x_cnt_q + W_BITS'(1);
              end
            end
          endcase
        end
      end

      PAD: begin
        if (accept) begin
          if (pad_cnt_q == pad - 2'd1) begin
            pad_cnt_d = 2'd0;
            state_d   = (y_cnt_q == height_q) ? DONE : PIX;
          end else begin
            pad_cnt_d = pad_cnt_q + 2'd1;
          end
        end
      end

      DONE: begin
        done_d  = 1'b1;
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q     <= IDLE;
      width_q     <= '0;
      height_q    <= '0;
      phase_q     <= 2'd0;
      pad_cnt_q   <= 2'd0;
      x_cnt_q     <= '0;
      y_cnt_q     <= '0;
      b_hold_q    <= 8'd0;
      g_hold_q    <= 8'd0;
      color_b_q   <= 8'd0;
      color_g_q   <= 8'd0;
      color_r_q   <= 8'd0;
      pix_valid_q <= 1'b0;
      start_q     <= 1'b0;
      end_q       <= 1'b0;
      x_q         <= '0;
      y_q         <= '0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      width_q     <= width_d;
      height_q    <= height_d;
      phase_q     <= phase_d;
      pad_cnt_q   <= pad_cnt_d;
      x_cnt_q     <= x_cnt_d;
      y_cnt_q     <= y_cnt_d;
      b_hold_q    <= b_hold_d;
      g_hold_q    <= g_hold_d;
      color_b_q   <= color_b_d;
      color_g_q   <= color_g_d;
      color_r_q   <= color_r_d;
      pix_valid_q <= pix_valid_d;
      start_q     <= start_d;
      end_q       <= end_d;
      x_q         <= x_d;
      y_q         <= y_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  assign fs.o_byte_ready       = byte_ready;
  assign fs.o_color_b          = color_b_q;
  assign fs.o_color_g          = color_g_q;
  assign fs.o_color_r          = color_r_q;
  assign fs.o_pix_valid        = pix_valid_q;
  assign fs.o_start_frame_flag = start_q;
  assign fs.o_end_frame_flag   = end_q;
  assign fs.o_x                = x_q;
  assign fs.o_y                = y_q;
  assign o_busy                = (state_q != IDLE);
  assign o_frame_done          = done_q;
  assign o_err                 = err_q;

endmodule
